speed_ctrl: RTL

Sets the division ratio for the playback-rate tick counter. Turns three pushbutton levels (faster, slower, restore) into a saturating 32-bit `max_count` value. The counter that directly follows it consumes that value and produces the sample tick. Holding a button auto-repeats the adjustment after a delay.

---
 rtl/speed_if.sv | 31 +++
 rtl/speed_ctrl.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/speed_if.sv
// Button levels in, divider value and status flags out,
// between the speed controller and its user.
interface speed_if;
  logic        speed_up;
  logic        speed_down;
  logic        speed_reset;
  logic [31:0] max_count;
  logic        changed;
  logic        at_min;
  logic        at_max;

  modport master (
    output speed_up,
    output speed_down,
    output speed_reset,
    input  max_count,
    input  changed,
    input  at_min,
    input  at_max
  );

  modport slave (
    input  speed_up,
    input  speed_down,
    input  speed_reset,
    output max_count,
    output changed,
    output at_min,
    output at_max
  );
endinterface

// File: rtl/speed_ctrl.sv
// Playback-rate divider control: pushbuttons step a saturating
// max_count, with hold-to-repeat after a delay.
module speed_ctrl #(
  parameter logic [31:0] DEFAULT_COUNT = 32'd2272,
  parameter logic [31:0] STEP          = 32'd16,
  parameter logic [31:0] MIN_COUNT     = 32'd1136,
  parameter logic [31:0] MAX_COUNT     = 32'd4544,
  parameter logic [31:0] REPEAT_DELAY  = 32'd25_000_000,
  parameter logic [31:0] REPEAT_RATE   = 32'd5_000_000
) (
  input  logic     clk,
  input  logic     reset,
  speed_if.slave   bus
);

  typedef enum logic [2:0] {
    IDLE,
    HOLD_UP,
    HOLD_DN,
    RPT_UP,
    RPT_DN
  } state_t;

  state_t      state;
  state_t      state_n;
  logic [31:0] rc;
  logic [31:0] rc_n;
  logic [31:0] mc_q;
  logic [31:0] mc_n;
  logic        changed_q;
  logic        at_min_q;
  logic        at_max_q;

  // bit order: {restore, down, up}
  logic [2:0] s1;
  logic [2:0] s2;
  logic [2:0] s3;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1 <= '0;
      s2 <= '0;
      s3 <= '0;
    end else begin
      s1 <= {bus.speed_reset, bus.speed_down, bus.speed_up};
      s2 <= s1;
      s3 <= s2;
    end
  end

  logic up_lvl;
  logic dn_lvl;
  logic rst_lvl;
  logic up_rise;
  logic dn_rise;

  assign up_lvl  = s2[0];
  assign dn_lvl  = s2[1];
  assign rst_lvl = s2[2];
  assign up_rise = s2[0] & ~s3[0];
  assign dn_rise = s2[1] & ~s3[1];

  // 33-bit arithmetic exposes wrap in either direction
  logic [32:0] dec;
  logic [32:0] inc;
  logic [31:0] up_val;
  logic [31:0] dn_val;

  always_comb begin
    dec = {1'b0, mc_q} - {1'b0, STEP};
    inc = {1'b0, mc_q} + {1'b0, STEP};
    if (dec[32] || (dec[31:0] < MIN_COUNT))
      up_val = MIN_COUNT;
    else
      up_val = dec[31:0];
    if (inc > {1'b0, MAX_COUNT})
      dn_val = MAX_COUNT;
    else
      dn_val = inc[31:0];
  end

  always_comb begin
    state_n = state;
    rc_n    = rc;
    mc_n    = mc_q;
    if (rst_lvl) begin
      state_n = IDLE;
      rc_n    = '0;
      mc_n    = DEFAULT_COUNT;
    end else if (up_lvl && dn_lvl) begin
      state_n = IDLE;
      rc_n    = '0;
    end else begin
      unique case (state)
        IDLE: begin
          rc_n = '0;
          if (up_rise) begin
            mc_n    = up_val;
            state_n = HOLD_UP;
          end else if (dn_rise) begin
            mc_n    = dn_val;
            state_n = HOLD_DN;
          end
        end
        HOLD_UP: begin
          if (!up_lvl || dn_rise) begin
            state_n = IDLE;
            rc_n    = '0;
          end else if (rc == REPEAT_DELAY - 32'd1) begin
            mc_n    = up_val;
            state_n = RPT_UP;
            rc_n    = '0;
          end else begin
            rc_n = rc + 32'd1;
          end
        end
        HOLD_DN: begin
          if (!dn_lvl || up_rise) begin
            state_n = IDLE;
            rc_n    = '0;
          end else if (rc == REPEAT_DELAY - 32'd1) begin
            mc_n    = dn_val;
            state_n = RPT_DN;
            rc_n    = '0;
          end else begin
            rc_n = rc + 32'd1;
          end
        end
        RPT_UP: begin
          if (!up_lvl || dn_lvl) begin
            state_n = IDLE;
            rc_n    = '0;
          end else if (rc == REPEAT_RATE - 32'd1) begin
            mc_n = up_val;
            rc_n = '0;
          end else begin
            rc_n = rc + 32'd1;
          end
        end
        RPT_DN: begin
          if (!dn_lvl || up_lvl) begin
            state_n = IDLE;
            rc_n    = '0;
          end else if (rc == REPEAT_RATE - 32'd1) begin
            mc_n = dn_val;
            rc_n = '0;
          end else begin
            rc_n = rc + 32'd1;
          end
        end
        default: begin
          state_n = IDLE;
          rc_n    = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      rc        <= '0;
      mc_q      <= DEFAULT_COUNT;
      changed_q <= 1'b0;
      at_min_q  <= (DEFAULT_COUNT == MIN_COUNT);
      at_max_q  <= (DEFAULT_COUNT == MAX_COUNT);
    end else begin
      state     <= state_n;
      rc        <= rc_n;
      mc_q      <= mc_n;
      changed_q <= (mc_n != mc_q);
      at_min_q  <= (mc_n == MIN_COUNT);
      at_max_q  <= (mc_n == MAX_COUNT);
    end
  end

  assign bus.max_count = mc_q;
  assign bus.changed   = changed_q;
  assign bus.at_min    = at_min_q;
  assign bus.at_max    = at_max_q;

endmodule
